// File: rtl/cam_dvp_tx_if.sv
// Wishbone slave bundle used for register and FIFO access to cam_dvp_tx.
interface cam_dvp_tx_if #(
  parameter int unsigned DataWidth = 32
);
  logic [2:0]           WBs_ADR_i;
  logic                 WBs_CYC_i;
  logic                 WBs_STB_i;
  logic                 WBs_WE_i;
  logic [DataWidth-1:0] WBs_DAT_i;
  logic [DataWidth-1:0] WBs_DAT_o;
  logic                 WBs_ACK_o;

  modport master (
    output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_DAT_i,
    input  WBs_DAT_o, WBs_ACK_o
  );

  modport slave (
    input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_DAT_i,
    output WBs_DAT_o, WBs_ACK_o
  );
endinterface

// File: rtl/cam_dvp_tx.sv
// Emulated DVP camera source: Wishbone-programmed frame timing, test pattern or FIFO-fed pixels.
module cam_dvp_tx #(
  parameter int unsigned          DATAWIDTH     = 32,
  parameter int unsigned          FIFO_DEPTH    = 4,
  parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  cam_dvp_tx_if.slave wb,
  output logic        PCLKO,
  output logic        VSYNCO,
  output logic        HREFO,
  output logic [7:0]  CAM_DAT_O
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StVblank = 2'd1, StActive = 2'd2, StHblank = 2'd3} state_e;

  state_e state_q, state_d;
  logic pclk_q, pclk_d, vsync_q, vsync_d, href_q, href_d;
  logic [7:0] dat_q, dat_d;
  logic ack_q, ack_d;
  logic [DATAWIDTH-1:0] rdat_q, rdat_d, status, head;
  logic en_q, en_d, mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic [10:0] ha_q, ha_d, sh_ha_q, sh_ha_d, pix_q, pix_d, ha_last;
  logic [7:0] hb_q, hb_d, sh_hb_q, sh_hb_d, vs_q, vs_d, sh_vs_q, sh_vs_d, vs_last;
  logic [9:0] vl_q, vl_d, sh_vl_q, sh_vl_d, line_q, line_d, vl_last;
  logic [7:0] cnt_q, cnt_d, frame_q, frame_d;
  logic [1:0] bidx_q, bidx_d;
  logic [31:0] word_q, word_d;
  logic unf_q, unf_d, ovf_q, ovf_d, unf_set, ovf_set;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
  logic wb_req, wb_wr, fifo_wr, w1c, full, push, pop;
  logic fall, line_done, frame_end, vblank_entry;

  // A fall slot is any cycle where PCLKO is high; it always drops on the next edge.
  assign fall         = pclk_q;
  assign wb_req       = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
  assign wb_wr        = wb_req & wb.WBs_WE_i;
  assign fifo_wr      = wb_wr & (wb.WBs_ADR_i == 3'd3);
  assign w1c          = wb_wr & (wb.WBs_ADR_i == 3'd5);
  assign full         = (level_q == LW'(FIFO_DEPTH));
  assign push         = fifo_wr & (~full | pop);
  assign ovf_set      = fifo_wr & full & ~pop;
  assign head         = mem_q[rd_ptr_q];
  // Zero-length fields behave as length one.
  assign vs_last      = (sh_vs_q == 8'd0)  ? 8'd0  : sh_vs_q - 8'd1;
  assign ha_last      = (sh_ha_q == 11'd0) ? 11'd0 : sh_ha_q - 11'd1;
  assign vl_last      = (sh_vl_q == 10'd0) ? 10'd0 : sh_vl_q - 10'd1;
  assign vblank_entry = fall & (state_d == StVblank) & (state_q != StVblank);

  always_comb begin
    status        = '0;
    status[2:0]   = 3'(level_q);
    status[4]     = unf_q;
    status[5]     = (state_q != StIdle);
    status[6]     = ovf_q;
    status[15:8]  = frame_q;
    status[17:16] = state_q;
  end

  // Register writes, read mux, sticky flags and frame counter.
  always_comb begin
    en_d = en_q; mode_d = mode_q; ha_d = ha_q; hb_d = hb_q; vl_d = vl_q; vs_d = vs_q;
    ack_d   = wb_req;
    rdat_d  = '0;
    if (wb_wr) begin
      unique case (wb.WBs_ADR_i)
        3'd0: begin en_d = wb.WBs_DAT_i[0]; mode_d = wb.WBs_DAT_i[1]; end
        3'd1: begin ha_d = wb.WBs_DAT_i[10:0]; hb_d = wb.WBs_DAT_i[23:16]; end
        3'd2: begin vl_d = wb.WBs_DAT_i[9:0]; vs_d = wb.WBs_DAT_i[23:16]; end
        default: ;
      endcase
    end
    if (wb_req && !wb.WBs_WE_i) begin
      unique case (wb.WBs_ADR_i)
        3'd0: begin rdat_d[0] = en_q; rdat_d[1] = mode_q; end
        3'd1: begin rdat_d[10:0] = ha_q; rdat_d[23:16] = hb_q; end
        3'd2: begin rdat_d[9:0] = vl_q; rdat_d[23:16] = vs_q; end
        3'd3: rdat_d = '0;
        3'd4, 3'd5: rdat_d = status;
        default: rdat_d = DEF_REG_VALUE;
      endcase
    end
    // A set event in the same cycle as its W1C wins.
    unf_d   = (unf_q & ~(w1c & wb.WBs_DAT_i[4])) | unf_set;
    ovf_d   = (ovf_q & ~(w1c & wb.WBs_DAT_i[6])) | ovf_set;
    frame_d = frame_q + 8'(frame_end);
  end

  // Register file state.
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      ack_q <= 1'b0; rdat_q <= '0; en_q <= 1'b0; mode_q <= 1'b0;
      ha_q <= 11'd64; hb_q <= 8'd8; vl_q <= 10'd4; vs_q <= 8'd4;
      unf_q <= 1'b0; ovf_q <= 1'b0; frame_q <= 8'd0;
    end else begin
      ack_q <= ack_d; rdat_q <= rdat_d; en_q <= en_d; mode_q <= mode_d;
      ha_q <= ha_d; hb_q <= hb_d; vl_q <= vl_d; vs_q <= vs_d;
      unf_q <= unf_d; ovf_q <= ovf_d; frame_q <= frame_d;
    end
  end

  // FSM state register.
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // FSM next state and position counters; only fall slots advance anything.
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; pix_d = pix_q; line_d = line_q;
    line_done = 1'b0; frame_end = 1'b0;
    if (fall) begin
      case (state_q)
        StIdle: if (en_q) begin state_d = StVblank; cnt_d = 8'd0; end
        StVblank: begin
          if (cnt_q == vs_last) begin
            state_d = StActive; pix_d = 11'd0; line_d = 10'd0;
          end else cnt_d = cnt_q + 8'd1;
        end
        StActive: begin
          if (pix_q == ha_last) begin
            if (sh_hb_q != 8'd0) begin state_d = StHblank; cnt_d = 8'd0; end
            else line_done = 1'b1;
          end else pix_d = pix_q + 11'd1;
        end
        StHblank: begin
          if (cnt_q == sh_hb_q - 8'd1) line_done = 1'b1;
          else cnt_d = cnt_q + 8'd1;
        end
        default: state_d = StIdle;
      endcase
      if (line_done) begin
        if (line_q == vl_last) begin
          frame_end = 1'b1;
          cnt_d     = 8'd0;
          state_d   = en_q ? StVblank : StIdle;
        end else begin
          state_d = StActive; line_d = line_q + 10'd1; pix_d = 11'd0;
        end
      end
    end
  end

  // Output generation: video signals, pixel byte source, shadow capture.
  always_comb begin
    pclk_d  = (en_q | (state_q != StIdle) | pclk_q) ? ~pclk_q : 1'b0;
    vsync_d = vsync_q; href_d = href_q; dat_d = dat_q;
    bidx_d  = bidx_q; word_d = word_q; pop = 1'b0; unf_set = 1'b0;
    sh_ha_d = sh_ha_q; sh_hb_d = sh_hb_q; sh_vl_d = sh_vl_q; sh_vs_d = sh_vs_q;
    sh_mode_d = sh_mode_q;
    if (vblank_entry) begin
      sh_ha_d = ha_q; sh_hb_d = hb_q; sh_vl_d = vl_q; sh_vs_d = vs_q; sh_mode_d = mode_q;
      bidx_d  = 2'd0;
    end
    if (fall) begin
      vsync_d = (state_d == StActive) | (state_d == StHblank);
      href_d  = (state_d == StActive);
      dat_d   = 8'd0;
      if (state_d == StActive) begin
        if (sh_mode_q) begin
          // word_q is a byte shift register; a group of four starts with a pop.
          if (bidx_q == 2'd0) begin
            if (level_q != '0) begin
              pop    = 1'b1;
              dat_d  = head[31:24];
              word_d = {head[23:0], 8'h00};
            end else begin
              unf_set = 1'b1;
              word_d  = 32'h0;
            end
          end else begin
            dat_d  = word_q[31:24];
            word_d = {word_q[23:0], 8'h00};
          end
          bidx_d = bidx_q + 2'd1;
        end else begin
          dat_d = pix_d[7:0] + line_d[7:0];
        end
      end
    end
  end

  // Video datapath state.
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      pclk_q <= 1'b0; vsync_q <= 1'b0; href_q <= 1'b0; dat_q <= 8'd0;
      cnt_q <= 8'd0; pix_q <= 11'd0; line_q <= 10'd0; bidx_q <= 2'd0; word_q <= 32'h0;
      sh_ha_q <= 11'd64; sh_hb_q <= 8'd8; sh_vl_q <= 10'd4; sh_vs_q <= 8'd4; sh_mode_q <= 1'b0;
    end else begin
      pclk_q <= pclk_d; vsync_q <= vsync_d; href_q <= href_d; dat_q <= dat_d;
      cnt_q <= cnt_d; pix_q <= pix_d; line_q <= line_d; bidx_q <= bidx_d; word_q <= word_d;
      sh_ha_q <= sh_ha_d; sh_hb_q <= sh_hb_d; sh_vl_q <= sh_vl_d; sh_vs_q <= sh_vs_d;
      sh_mode_q <= sh_mode_d;
    end
  end

  // FIFO pointer and level bookkeeping.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FIFO control state.
  always_ff @(posedge WBs_CLK_i) begin
    if (!WBs_RST_i) begin
      wr_ptr_q <= '0; rd_ptr_q <= '0; level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; level_q <= level_d;
    end
  end

  // FIFO storage; contents are don't-care while the level says empty.
  always_ff @(posedge WBs_CLK_i) begin
    if (push) mem_q[wr_ptr_q] <= wb.WBs_DAT_i;
  end

  assign PCLKO        = pclk_q;
  assign VSYNCO       = vsync_q;
  assign HREFO        = href_q;
  assign CAM_DAT_O    = dat_q;
  assign wb.WBs_DAT_o = rdat_q;
  assign wb.WBs_ACK_o = ack_q;
endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx: register table, directed frames, random frames vs model.
module tb_cam_dvp_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_dvp_tx_if wb_if ();
  logic       pclk, vsy, hrf;
  logic [7:0] dat;

  cam_dvp_tx dut (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst_n),
    .wb        (wb_if),
    .PCLKO     (pclk),
    .VSYNCO    (vsy),
    .HREFO     (hrf),
    .CAM_DAT_O (dat)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Receiver view: one {VSYNC, HREF, DATA} sample per PCLKO rising edge.
  logic [9:0] cap[$];
  logic       pclk_prev = 1'b0;
  always @(negedge clk) begin
    if (!pclk_prev && pclk) cap.push_back({vsy, hrf, dat});
    pclk_prev = pclk;
  end

  // Reference model state.
  logic [31:0] mq[$];
  bit m_unf, m_ovf;
  int m_frames;
  int t_ha = 64, t_hb = 8, t_vl = 4, t_vs = 4;

  task automatic model_reset();
    mq.delete(); m_unf = 0; m_ovf = 0; m_frames = 0;
    t_ha = 64; t_hb = 8; t_vl = 4; t_vs = 4;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] d);
    wb_if.WBs_ADR_i = a; wb_if.WBs_DAT_i = d; wb_if.WBs_WE_i = 1'b1;
    wb_if.WBs_CYC_i = 1'b1; wb_if.WBs_STB_i = 1'b1;
    @(posedge clk); #1;
    wb_if.WBs_CYC_i = 1'b0; wb_if.WBs_STB_i = 1'b0; wb_if.WBs_WE_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
    wb_if.WBs_ADR_i = a; wb_if.WBs_WE_i = 1'b0;
    wb_if.WBs_CYC_i = 1'b1; wb_if.WBs_STB_i = 1'b1;
    @(posedge clk); #1;
    check("ack_high", {31'b0, wb_if.WBs_ACK_o}, 32'd1);
    d = wb_if.WBs_DAT_o;
    wb_if.WBs_CYC_i = 1'b0; wb_if.WBs_STB_i = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse", {31'b0, wb_if.WBs_ACK_o}, 32'd0);
  endtask

  task automatic push_word(input logic [31:0] w);
    wb_write(3'd3, w);
    if (mq.size() < 4) mq.push_back(w);
    else m_ovf = 1;
  endtask

  task automatic w1c(input logic [31:0] v);
    wb_write(3'd5, v);
    if (v[4]) m_unf = 0;
    if (v[6]) m_ovf = 0;
  endtask

  task automatic set_timing(input int ha, input int hb, input int vl, input int vs);
    wb_write(3'd1, {8'h0, 8'(hb), 5'h0, 11'(ha)});
    wb_write(3'd2, {8'h0, 8'(vs), 6'h0, 10'(vl)});
    t_ha = ha; t_hb = hb; t_vl = vl; t_vs = vs;
  endtask

  function automatic logic [31:0] exp_status();
    return {14'h0, 2'b00, 8'(m_frames), 1'b0, m_ovf, 1'b0, m_unf, 1'b0, 3'(mq.size())};
  endfunction

  task automatic check_status(input string nm);
    logic [31:0] r;
    wb_read(3'd4, r);
    check(nm, r, exp_status());
  endtask

  // Run one frame from IDLE. With late=1, EN is dropped and HTIM rewritten during line 0.
  task automatic run_frame(input bit mode, input bit late, input int new_ha, input int new_hb);
    logic [9:0]  exp[$];
    logic [31:0] cur, r;
    logic [7:0]  b;
    int bi, vse, hae, vle, idx;
    bit done, seen;
    cur = 0; bi = 0;
    vse = (t_vs == 0) ? 1 : t_vs;
    hae = (t_ha == 0) ? 1 : t_ha;
    vle = (t_vl == 0) ? 1 : t_vl;
    exp.push_back(10'h0);  // idle sample on the first PCLK rise
    repeat (vse) exp.push_back(10'h0);
    for (int l = 0; l < vle; l++) begin
      for (int p = 0; p < hae; p++) begin
        if (mode) begin
          if (bi == 0) begin
            if (mq.size() > 0) cur = mq.pop_front();
            else begin cur = 0; m_unf = 1; end
          end
          b  = cur[31 - 8*bi -: 8];
          bi = (bi + 1) % 4;
        end else begin
          b = 8'(p + l);
        end
        exp.push_back({2'b11, b});
      end
      repeat (t_hb) exp.push_back(10'h200);
    end
    m_frames++;

    cap.delete();
    wb_write(3'd0, {30'h0, mode, 1'b1});
    if (!late) begin
      wb_write(3'd0, {30'h0, mode, 1'b0});
    end else begin
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
        @(posedge clk); #1;
        seen = hrf;
      end
      check("href_seen", {31'b0, seen}, 32'd1);
      wb_write(3'd0, {30'h0, mode, 1'b0});
      wb_write(3'd1, {8'h0, 8'(new_hb), 5'h0, 11'(new_ha)});
    end

    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      wb_read(3'd4, r);
      if (!r[5]) done = 1;
    end
    check("frame_done", {31'b0, done}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("pclk_idle", {31'b0, pclk}, 32'd0);
    check("frame_len", cap.size(), exp.size());
    idx = 0;
    for (int i = cap.size() - 1; i >= 0; i--) if (i < exp.size() && cap[i] !== exp[i]) idx = i;
    if (cap.size() > 0) check($sformatf("frame_data[%0d]", idx), {22'h0, cap[idx]}, {22'h0, exp[idx]});
    check_status("status_after_frame");
    if (late) begin t_ha = new_ha; t_hb = new_hb; end
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int np;
    bit md;
    wb_if.WBs_ADR_i = '0; wb_if.WBs_CYC_i = 1'b0; wb_if.WBs_STB_i = 1'b0;
    wb_if.WBs_WE_i = 1'b0; wb_if.WBs_DAT_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {21'h0, pclk, vsy, hrf, dat}, 32'h0);
    check("rst_ack", {31'b0, wb_if.WBs_ACK_o}, 32'd0);
    rst_n = 1'b1;

    // Register map: reset values, field masks, unmapped and write-only addresses.
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0008_0040});
    vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h0004_0004});
    vecs.push_back('{1'b0, 3'd3, 32'h0, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd5, 32'h0, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd6, 32'h0, 32'hFABD_EFAC});
    vecs.push_back('{1'b0, 3'd7, 32'h0, 32'hFABD_EFAC});
    vecs.push_back('{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h00FF_07FF});
    vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h0, 32'h00FF_03FF});
    vecs.push_back('{1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0});
    vecs.push_back('{1'b0, 3'd0, 32'h0, 32'h0000_0002});
    vecs.push_back('{1'b1, 3'd0, 32'h0, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h0008_0040, 32'h0});
    vecs.push_back('{1'b1, 3'd2, 32'h0004_0004, 32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h0, 32'h0008_0040});
    vecs.push_back('{1'b0, 3'd4, 32'h0, 32'h0000_0000});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) wb_write(vecs[i].adr, vecs[i].wd);
      else begin
        wb_read(vecs[i].adr, r);
        check($sformatf("reg_vec%0d_adr%0d", i, vecs[i].adr), r, vecs[i].exp);
      end
    end

    // Pattern frame 4x2 with blanking.
    set_timing(4, 2, 2, 3);
    run_frame(1'b0, 1'b0, 0, 0);

    // FIFO mode: two words fill eight bytes exactly.
    push_word(32'h1122_3344);
    push_word(32'h5566_7788);
    set_timing(8, 2, 1, 1);
    run_frame(1'b1, 1'b0, 0, 0);

    // FIFO mode: one word, second group underflows, then W1C clears it.
    push_word(32'h1122_3344);
    run_frame(1'b1, 1'b0, 0, 0);
    w1c(32'h0000_0010);
    check_status("unf_cleared");

    // Overflow: fifth push dropped and never transmitted.
    for (int i = 0; i < 5; i++) push_word(32'hA0B0_C0D0 + i);
    check_status("overflow_level");
    set_timing(16, 1, 1, 1);
    run_frame(1'b1, 1'b0, 0, 0);
    w1c(32'h0000_0050);

    // EN dropped in line 0: frame completes; mid-frame HTIM only used by the next frame.
    set_timing(4, 2, 2, 3);
    run_frame(1'b0, 1'b1, 3, 1);
    run_frame(1'b0, 1'b0, 0, 0);

    // Random frames against the model.
    for (int k = 0; k < 25; k++) begin
      np = $urandom_range(0, 5);
      md = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) w1c(32'h0000_0050);
      for (int j = 0; j < np; j++) push_word($urandom);
      set_timing($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      run_frame(md, 1'b0, 0, 0);
    end

    // Reset during ACTIVE aborts at once.
    set_timing(4, 2, 2, 3);
    wb_write(3'd0, 32'h1);
    np = 0;
    for (int i = 0; i < 2000 && np == 0; i++) begin
      @(posedge clk); #1;
      np = int'(hrf);
    end
    check("active_before_reset", np, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs", {21'h0, pclk, vsy, hrf, dat}, 32'h0);
    rst_n = 1'b1;
    model_reset();
    wb_read(3'd4, r);
    check("reset_status", r, 32'h0);
    wb_read(3'd1, r);
    check("reset_htim", r, 32'h0008_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
